// File: rtl/bnn_ctrl_pkg.sv
// Shared types and default constants for the BNN inference sequencer.
// Imported by the sequencer top and its timer sub-module.
package bnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IMG = 3'd1,
        ST_RUN      = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_DONE     = 3'd4
    } ctrl_state_t;

    localparam logic [3:0]  ERR_DIGIT          = 4'hF;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd65536;
    localparam int unsigned DEF_CLEAR_CYCLES   = 32'd8;
    localparam int unsigned DEF_TMR_W          = 32'd20;

endpackage

// File: rtl/bnn_ctrl_timer.sv
// Up-counter with synchronous clear-to-zero, count enable and a terminal-count flag.
// The flag fires only while counting, so it marks the last cycle of a timed phase.
module bnn_ctrl_timer #(
    parameter int unsigned W = 32'd20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins over enable
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/bnn_inference_ctrl.sv
// Sequencer for one BNN inference per host request: waits for a buffered image, runs the
// wrapper with a timeout, flushes its result pipeline with a clear pulse, then hands the result over.
module bnn_inference_ctrl
    import bnn_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
    parameter int unsigned TMR_W          = DEF_TMR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_req,
    input  logic       abort_req,
    input  logic       img_buffer_full,
    output logic       img_consumed,
    output logic       bnn_enable,
    output logic       bnn_clear,
    input  logic       bnn_result_ready,
    input  logic [3:0] bnn_result,
    output logic       result_valid,
    output logic [3:0] result_digit,
    output logic       result_err,
    input  logic       result_ack,
    output logic       busy,
    output logic [7:0] infer_count
);

    localparam logic [TMR_W-1:0] RUN_TERM   = TMR_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TMR_W-1:0] CLEAR_TERM = TMR_W'(CLEAR_CYCLES - 32'd1);

    ctrl_state_t state_q, state_d;
    logic [3:0]  digit_q, digit_d;
    logic        err_q, err_d;
    logic [7:0]  count_q, count_d;
    logic        enable_q, clear_q, consumed_q, valid_q, busy_q;
    logic        run_tc_s, clr_tc_s;

    // Each timer is held at zero outside its own state, so it restarts on every entry.
    bnn_ctrl_timer #(.W(TMR_W)) u_run_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_RUN),
        .en_i   (state_q == ST_RUN),
        .term_i (RUN_TERM),
        .tc_o   (run_tc_s)
    );

    bnn_ctrl_timer #(.W(TMR_W)) u_clear_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_CLEAR),
        .en_i   (state_q == ST_CLEAR),
        .term_i (CLEAR_TERM),
        .tc_o   (clr_tc_s)
    );

    // next state and result capture; a ready result beats abort, abort beats timeout
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (img_buffer_full) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT_IMG;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IMG: begin
                if (img_buffer_full) begin
                    state_d = ST_RUN;
                end else if (abort_req) begin
                    state_d = ST_DONE;
                    digit_d = ERR_DIGIT;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT_IMG;
                end
            end
            ST_RUN: begin
                if (bnn_result_ready) begin
                    state_d = ST_CLEAR;
                    digit_d = bnn_result;
                    err_d   = 1'b0;
                    count_d = count_q + 8'd1;
                end else if (abort_req || run_tc_s) begin
                    state_d = ST_CLEAR;
                    digit_d = ERR_DIGIT;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                if (clr_tc_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                if (result_ack || abort_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, captured result and outputs decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            digit_q    <= 4'h0;
            err_q      <= 1'b0;
            count_q    <= 8'd0;
            enable_q   <= 1'b0;
            clear_q    <= 1'b0;
            consumed_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            err_q      <= err_d;
            count_q    <= count_d;
            enable_q   <= (state_d == ST_RUN);
            clear_q    <= (state_d == ST_CLEAR);
            consumed_q <= (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
            valid_q    <= (state_d == ST_DONE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign img_consumed = consumed_q;
    assign bnn_enable   = enable_q;
    assign bnn_clear    = clear_q;
    assign result_valid = valid_q;
    assign result_digit = digit_q;
    assign result_err   = err_q;
    assign busy         = busy_q;
    assign infer_count  = count_q;

endmodule

// File: tb/tb_bnn_inference_ctrl.sv
// Directed bench for bnn_inference_ctrl: one default-timeout instance for the main flows
// and a TIMEOUT_CYCLES=32 instance for the timeout case.
module tb_bnn_inference_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start_req, start_req_b, abort_req, img_buffer_full;
    logic       bnn_result_ready, result_ack;
    logic [3:0] bnn_result;

    logic       img_consumed, bnn_enable, bnn_clear, result_valid, result_err, busy;
    logic [3:0] result_digit;
    logic [7:0] infer_count;

    logic       cons_b, en_b, clr_b, valid_b, err_b, busy_b;
    logic [3:0] digit_b;
    logic [7:0] count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt = 0, clr_cnt = 0, cons_cnt = 0;
    int en_cnt_b = 0, clr_cnt_b = 0, cons_cnt_b = 0;
    int e0, c0, k0;

    always #5 clk = ~clk;

    bnn_inference_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_req(start_req), .abort_req(abort_req),
        .img_buffer_full(img_buffer_full), .img_consumed(img_consumed),
        .bnn_enable(bnn_enable), .bnn_clear(bnn_clear),
        .bnn_result_ready(bnn_result_ready), .bnn_result(bnn_result),
        .result_valid(result_valid), .result_digit(result_digit), .result_err(result_err),
        .result_ack(result_ack), .busy(busy), .infer_count(infer_count)
    );

    bnn_inference_ctrl #(.TIMEOUT_CYCLES(32'd32), .CLEAR_CYCLES(32'd8), .TMR_W(32'd20)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_req(start_req_b), .abort_req(abort_req),
        .img_buffer_full(img_buffer_full), .img_consumed(cons_b),
        .bnn_enable(en_b), .bnn_clear(clr_b),
        .bnn_result_ready(1'b0), .bnn_result(4'h0),
        .result_valid(valid_b), .result_digit(digit_b), .result_err(err_b),
        .result_ack(result_ack), .busy(busy_b), .infer_count(count_b)
    );

    // cycle counters of high outputs, used to measure pulse lengths
    always @(posedge clk) begin
        if (bnn_enable)   en_cnt     <= en_cnt + 1;
        if (bnn_clear)    clr_cnt    <= clr_cnt + 1;
        if (img_consumed) cons_cnt   <= cons_cnt + 1;
        if (en_b)         en_cnt_b   <= en_cnt_b + 1;
        if (clr_b)        clr_cnt_b  <= clr_cnt_b + 1;
        if (cons_b)       cons_cnt_b <= cons_cnt_b + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (result_valid === 1'b1) break;
            @(negedge clk);
        end
        chk1(tag, result_valid, 1'b1);
    endtask

    // called at the first RUN negedge; optionally fires stray start pulses in RUN and CLEAR
    task automatic finish_infer(input logic [3:0] d, input int dly, input bit spur);
        if (spur) start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (dly) @(negedge clk);
        bnn_result = d;
        bnn_result_ready = 1'b1;
        @(negedge clk);
        chk1("clr_lat", bnn_clear, 1'b1);
        chk8("cap_digit", {4'h0, result_digit}, {4'h0, d});
        if (spur) start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        bnn_result_ready = 1'b0;
        wait_valid("done_valid");
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk1("back_idle", busy, 1'b0);
    endtask

    task automatic do_infer(input logic [3:0] d, input int dly, input bit spur);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk1("run_lat", bnn_enable, 1'b1);
        finish_infer(d, dly, spur);
    endtask

    initial begin
        rst_n = 1'b0; start_req = 1'b0; start_req_b = 1'b0; abort_req = 1'b0;
        img_buffer_full = 1'b0; bnn_result_ready = 1'b0; bnn_result = 4'h0; result_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_enable", bnn_enable, 1'b0);
        chk1("rst_clear", bnn_clear, 1'b0);
        chk1("rst_valid", result_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk8("rst_count", infer_count, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // buffer full, result 7 after 40 RUN cycles, ready left high through CLEAR
        img_buffer_full = 1'b1;
        e0 = en_cnt; c0 = clr_cnt; k0 = cons_cnt;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk1("t1_en_lat", bnn_enable, 1'b1);
        chk1("t1_busy", busy, 1'b1);
        repeat (39) @(negedge clk);
        chk1("t1_en_held", bnn_enable, 1'b1);
        bnn_result = 4'd7;
        bnn_result_ready = 1'b1;
        @(negedge clk);
        chk1("t1_clear", bnn_clear, 1'b1);
        chk1("t1_en_off", bnn_enable, 1'b0);
        chk1("t1_consumed", img_consumed, 1'b1);
        chk8("t1_digit", {4'h0, result_digit}, 8'h07);
        chk1("t1_err", result_err, 1'b0);
        chk8("t1_count", infer_count, 8'd1);
        repeat (8) @(negedge clk);
        chk1("t1_valid", result_valid, 1'b1);
        chk1("t1_clear_off", bnn_clear, 1'b0);
        chkn("t1_en_len", en_cnt - e0, 40);
        chkn("t1_clr_len", clr_cnt - c0, 8);
        chkn("t1_cons_len", cons_cnt - k0, 1);
        bnn_result_ready = 1'b0;
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk1("t1_valid_off", result_valid, 1'b0);
        chk1("t1_idle", busy, 1'b0);

        // start with empty buffer, buffer fills 100 cycles later
        img_buffer_full = 1'b0;
        e0 = en_cnt;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk1("t2_busy", busy, 1'b1);
        chk1("t2_no_en", bnn_enable, 1'b0);
        repeat (99) @(negedge clk);
        chkn("t2_en_none", en_cnt - e0, 0);
        img_buffer_full = 1'b1;
        @(negedge clk);
        chk1("t2_en_lat", bnn_enable, 1'b1);
        finish_infer(4'd3, 5, 1'b0);
        chk8("t2_count", infer_count, 8'd2);

        // timeout on the 32-cycle instance
        e0 = en_cnt_b; c0 = clr_cnt_b; k0 = cons_cnt_b;
        start_req_b = 1'b1;
        @(negedge clk);
        start_req_b = 1'b0;
        chk1("t3_en_lat", en_b, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (valid_b === 1'b1) break;
            @(negedge clk);
        end
        chk1("t3_valid", valid_b, 1'b1);
        chkn("t3_en_len", en_cnt_b - e0, 32);
        chkn("t3_clr_len", clr_cnt_b - c0, 8);
        chkn("t3_cons_len", cons_cnt_b - k0, 1);
        chk8("t3_digit", {4'h0, digit_b}, 8'h0F);
        chk1("t3_err", err_b, 1'b1);
        chk8("t3_count", count_b, 8'd0);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk1("t3_idle", busy_b, 1'b0);

        // result ready and abort in the same RUN cycle
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        bnn_result = 4'd5;
        bnn_result_ready = 1'b1;
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        bnn_result_ready = 1'b0;
        chk1("t4_clear", bnn_clear, 1'b1);
        chk8("t4_digit", {4'h0, result_digit}, 8'h05);
        chk1("t4_err", result_err, 1'b0);
        chk8("t4_count", infer_count, 8'd3);
        wait_valid("t4_valid");
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;

        // abort while waiting for the image: straight to DONE, no clear pulse
        img_buffer_full = 1'b0;
        c0 = clr_cnt;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        chk1("t5_valid", result_valid, 1'b1);
        chk1("t5_err", result_err, 1'b1);
        chk8("t5_digit", {4'h0, result_digit}, 8'h0F);
        chkn("t5_no_clear", clr_cnt - c0, 0);
        chk8("t5_count", infer_count, 8'd3);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk1("t5_idle", busy, 1'b0);

        // abort in RUN, ignored abort in CLEAR, abort leaving DONE
        img_buffer_full = 1'b1;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        abort_req = 1'b1;
        @(negedge clk);
        chk1("t6_clear", bnn_clear, 1'b1);
        chk8("t6_digit", {4'h0, result_digit}, 8'h0F);
        chk1("t6_err", result_err, 1'b1);
        @(negedge clk);
        abort_req = 1'b0;
        chk1("t6_clear_held", bnn_clear, 1'b1);
        wait_valid("t6_valid");
        chk8("t6_count", infer_count, 8'd3);
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        chk1("t6_abort_idle", busy, 1'b0);
        chk1("t6_valid_off", result_valid, 1'b0);

        // asynchronous reset in the middle of RUN
        c0 = clr_cnt;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("t7_en_async", bnn_enable, 1'b0);
        chk1("t7_busy_async", busy, 1'b0);
        chk8("t7_count_async", infer_count, 8'd0);
        chk8("t7_digit_async", {4'h0, result_digit}, 8'h00);
        chk1("t7_err_async", result_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chkn("t7_no_clear", clr_cnt - c0, 0);
        chk1("t7_idle", busy, 1'b0);
        do_infer(4'd9, 10, 1'b0);
        chk8("t7_count", infer_count, 8'd1);

        // back-to-back inferences with stray start pulses; count wraps to 0
        for (int i = 0; i < 255; i++) begin
            do_infer(4'(i % 10), 2, 1'b1);
            chk8("t8_count", infer_count, 8'(i + 2));
        end
        chk8("t8_wrap", infer_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
